// File: rtl/aibcr3_latch_upd_pkg.sv
// Shared types and helpers for the aibcr3 latch update sequencer.
// The state enum and counter sizing live here so the top and counter agree.
package aibcr3_latch_upd_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        EN,
        HOLD,
        CLR,
        ACK
    } state_e;

    // Width that holds the largest phase length; one spare bit keeps the
    // result at least one bit wide when every phase length is 1.
    function automatic int cnt_width(input int setup_cyc, input int en_cyc,
                                     input int hold_cyc, input int rst_hold);
        int m;
        m = setup_cyc;
        if (en_cyc > m)   m = en_cyc;
        if (hold_cyc > m) m = hold_cyc;
        if (rst_hold > m) m = rst_hold;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/aibcr3_latch_upd_cnt.sv
// Loadable down-counter that saturates at zero; load takes priority over
// counting, and the zero flag is decoded straight from the count register.
module aibcr3_latch_upd_cnt #(
    parameter int             W       = 3,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign zero = (cnt_q == '0);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (!zero) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aibcr3_latch_upd_ctrl.sv
// Sequencer for a bank of aibcr3_latch cells: frames every code update with
// setup/enable/hold phases and drives clears and reset exit through CDN.
module aibcr3_latch_upd_ctrl
    import aibcr3_latch_upd_pkg::*;
#(
    parameter int CODE_W    = 10,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 2,
    parameter int RST_HOLD  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              upd_req,
    input  logic [CODE_W-1:0] upd_code,
    input  logic              clr_req,
    output logic              busy,
    output logic              upd_ack,
    output logic [CODE_W-1:0] latch_d,
    output logic              latch_en,
    output logic              latch_cdn
);

    localparam int CNT_W = cnt_width(SETUP_CYC, EN_CYC, HOLD_CYC, RST_HOLD);

    // Counter reload values: a phase of N cycles counts N-1 down to zero.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_HOLD - 1);

    state_e              state_q,     state_d;
    logic [CODE_W-1:0]   latch_d_q,   latch_d_d;
    logic                latch_en_q,  latch_en_d;
    logic                latch_cdn_q, latch_cdn_d;
    logic                busy_q,      busy_d;
    logic                upd_ack_q,   upd_ack_d;
    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_val;
    logic                cnt_zero;

    aibcr3_latch_upd_cnt #(
        .W       (CNT_W),
        .RST_VAL (RST_LD)
    ) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        latch_d_d   = latch_d_q;
        latch_en_d  = latch_en_q;
        latch_cdn_d = latch_cdn_q;
        upd_ack_d   = 1'b0;
        cnt_load    = 1'b0;
        cnt_val     = '0;

        case (state_q)
            INIT: begin
                latch_cdn_d = 1'b0;
                if (cnt_zero) begin
                    state_d     = IDLE;
                    latch_cdn_d = 1'b1;
                end
            end
            IDLE: begin
                // Clear wins over a simultaneous update request.
                if (clr_req) begin
                    state_d     = CLR;
                    latch_d_d   = '0;
                    latch_cdn_d = 1'b0;
                    cnt_load    = 1'b1;
                    cnt_val     = EN_LD;
                end else if (upd_req) begin
                    state_d   = SETUP;
                    latch_d_d = upd_code;
                    cnt_load  = 1'b1;
                    cnt_val   = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d    = EN;
                    latch_en_d = 1'b1;
                    cnt_load   = 1'b1;
                    cnt_val    = EN_LD;
                end
            end
            EN: begin
                if (cnt_zero) begin
                    state_d    = HOLD;
                    latch_en_d = 1'b0;
                    cnt_load   = 1'b1;
                    cnt_val    = HOLD_LD;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_d   = ACK;
                    upd_ack_d = 1'b1;
                end
            end
            CLR: begin
                if (cnt_zero) begin
                    state_d     = ACK;
                    latch_cdn_d = 1'b1;
                    upd_ack_d   = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = INIT;
                latch_en_d  = 1'b0;
                latch_cdn_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            latch_d_q   <= '0;
            latch_en_q  <= 1'b0;
            latch_cdn_q <= 1'b0;
            busy_q      <= 1'b1;
            upd_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            latch_d_q   <= latch_d_d;
            latch_en_q  <= latch_en_d;
            latch_cdn_q <= latch_cdn_d;
            busy_q      <= busy_d;
            upd_ack_q   <= upd_ack_d;
        end
    end

    assign busy      = busy_q;
    assign upd_ack   = upd_ack_q;
    assign latch_d   = latch_d_q;
    assign latch_en  = latch_en_q;
    assign latch_cdn = latch_cdn_q;

endmodule

// File: tb/tb_aibcr3_latch_upd_ctrl.sv
// Self-checking bench: a timeline model (operation + edges elapsed) is compared
// against the sequencer every cycle, alongside directed literal expectations.
module tb_aibcr3_latch_upd_ctrl;

    localparam int CODE_W    = 10;
    localparam int SETUP_CYC = 2;
    localparam int EN_CYC    = 2;
    localparam int HOLD_CYC  = 2;
    localparam int RST_HOLD  = 4;
    localparam int UPD_LEN   = SETUP_CYC + EN_CYC + HOLD_CYC + 1;
    localparam int CLR_LEN   = EN_CYC + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              upd_req;
    logic              clr_req;
    logic [CODE_W-1:0] upd_code;
    logic              busy;
    logic              upd_ack;
    logic [CODE_W-1:0] latch_d;
    logic              latch_en;
    logic              latch_cdn;

    aibcr3_latch_upd_ctrl #(
        .CODE_W    (CODE_W),
        .SETUP_CYC (SETUP_CYC),
        .EN_CYC    (EN_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .RST_HOLD  (RST_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .upd_req   (upd_req),
        .upd_code  (upd_code),
        .clr_req   (clr_req),
        .busy      (busy),
        .upd_ack   (upd_ack),
        .latch_d   (latch_d),
        .latch_en  (latch_en),
        .latch_cdn (latch_cdn)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: which operation is running and how many edges since it began.
    typedef enum int {M_INIT, M_IDLE, M_UPD, M_CLR} mop_e;
    mop_e              m_op = M_INIT;
    int                m_k  = 0;
    logic [CODE_W-1:0] m_d  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op <= M_INIT;
            m_k  <= 0;
            m_d  <= '0;
        end else if (m_op == M_IDLE) begin
            if (clr_req) begin
                m_op <= M_CLR;
                m_k  <= 0;
                m_d  <= '0;
            end else if (upd_req) begin
                m_op <= M_UPD;
                m_k  <= 0;
                m_d  <= upd_code;
            end
        end else begin
            m_k <= m_k + 1;
            if ((m_op == M_INIT && m_k + 1 == RST_HOLD) ||
                (m_op == M_UPD  && m_k + 1 == UPD_LEN)  ||
                (m_op == M_CLR  && m_k + 1 == CLR_LEN))
                m_op <= M_IDLE;
        end
    end

    logic              en_prev = 1'b0;
    logic [CODE_W-1:0] d_prev  = '0;
    int                d_age   = 0;
    int                en_age  = 100;

    always @(negedge clk) begin
        check("busy", busy, m_op != M_IDLE);
        check("latch_d", latch_d, m_d);
        check("latch_en", latch_en,
              m_op == M_UPD && m_k >= SETUP_CYC && m_k < SETUP_CYC + EN_CYC);
        check("latch_cdn", latch_cdn,
              !(m_op == M_INIT || (m_op == M_CLR && m_k < EN_CYC)));
        check("upd_ack", upd_ack,
              (m_op == M_UPD && m_k == SETUP_CYC + EN_CYC + HOLD_CYC) ||
              (m_op == M_CLR && m_k == EN_CYC));
        check("en_cdn_excl", latch_en & ~latch_cdn, 1'b0);
        if (!rst_n) begin
            d_age  <= 0;
            en_age <= 100;
        end else begin
            if (latch_d != d_prev) begin
                check("hold_margin", en_age >= HOLD_CYC, 1'b1);
                d_age <= 0;
            end else begin
                d_age <= d_age + 1;
            end
            if (latch_en && !en_prev)
                check("setup_margin", d_age + 1 >= SETUP_CYC, 1'b1);
            en_age <= latch_en ? 0 : en_age + 1;
        end
        d_prev  <= latch_d;
        en_prev <= latch_en;
    end

    task automatic reset_exit();
        int n;
        n = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (latch_cdn) break;
        end
        check("rst_cdn_low_cycles", n, RST_HOLD);
        check("rst_busy_falls", busy, 1'b0);
    endtask

    task automatic run_op(input logic u, input logic c, input logic [CODE_W-1:0] code,
                          input int pulse_at,
                          output int en_first, output int en_n, output int cdn_n,
                          output int ack_n, output int ack_edge, output int idle_edge);
        en_first = -1; en_n = 0; cdn_n = 0; ack_n = 0; ack_edge = -1; idle_edge = -1;
        @(negedge clk);
        upd_req  = u;
        clr_req  = c;
        upd_code = code;
        @(posedge clk);
        #1;
        upd_req = 1'b0;
        clr_req = 1'b0;
        if (!latch_cdn) cdn_n++;
        for (int i = 1; i <= 30 && idle_edge < 0; i++) begin
            if (i == pulse_at) begin
                upd_req  = 1'b1;
                upd_code = 10'h3FF;
            end
            @(posedge clk);
            #1;
            if (i == pulse_at) upd_req = 1'b0;
            if (latch_en) begin
                en_n++;
                if (en_first < 0) en_first = i;
            end
            if (!latch_cdn) cdn_n++;
            if (upd_ack) begin
                ack_n++;
                ack_edge = i;
            end
            if (!busy) idle_edge = i;
        end
    endtask

    int ef, en, cn, an, ae, ie;

    initial begin
        rst_n    = 1'b0;
        upd_req  = 1'b0;
        clr_req  = 1'b0;
        upd_code = '0;
        #12;
        check("rst_latch_cdn", latch_cdn, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_latch_en", latch_en, 1'b0);
        check("rst_latch_d", latch_d, 10'h000);
        check("rst_upd_ack", upd_ack, 1'b0);
        reset_exit();

        // Single update
        run_op(1'b1, 1'b0, 10'h2A5, 0, ef, en, cn, an, ae, ie);
        check("upd_latch_d", latch_d, 10'h2A5);
        check("upd_en_first", ef, 2);
        check("upd_en_cycles", en, 2);
        check("upd_cdn_low", cn, 0);
        check("upd_ack_count", an, 1);
        check("upd_ack_edge", ae, 6);
        check("upd_idle_edge", ie, 7);

        // Clear
        run_op(1'b0, 1'b1, 10'h000, 0, ef, en, cn, an, ae, ie);
        check("clr_latch_d", latch_d, 10'h000);
        check("clr_en_cycles", en, 0);
        check("clr_cdn_low", cn, 2);
        check("clr_ack_count", an, 1);
        check("clr_ack_edge", ae, 2);
        check("clr_idle_edge", ie, 3);

        // Simultaneous requests after a fresh code: clear wins
        run_op(1'b1, 1'b0, 10'h0AA, 0, ef, en, cn, an, ae, ie);
        run_op(1'b1, 1'b1, 10'h155, 0, ef, en, cn, an, ae, ie);
        check("both_latch_d", latch_d, 10'h000);
        check("both_en_cycles", en, 0);
        check("both_cdn_low", cn, 2);
        check("both_ack_edge", ae, 2);

        // Request while busy is dropped
        run_op(1'b1, 1'b0, 10'h1C3, 3, ef, en, cn, an, ae, ie);
        check("busy_req_latch_d", latch_d, 10'h1C3);
        check("busy_req_ack_count", an, 1);
        check("busy_req_idle_edge", ie, 7);
        repeat (3) @(posedge clk);
        #1;
        check("busy_req_not_queued", busy, 1'b0);

        // Same code again still runs the whole sequence
        run_op(1'b1, 1'b0, 10'h1C3, 0, ef, en, cn, an, ae, ie);
        check("same_en_cycles", en, 2);
        check("same_ack_edge", ae, 6);

        // Reset while latch_en is high
        @(negedge clk);
        upd_req  = 1'b1;
        upd_code = 10'h0F0;
        @(posedge clk);
        #1;
        upd_req = 1'b0;
        for (int i = 0; i < 10 && !latch_en; i++) begin
            @(posedge clk);
            #1;
        end
        check("mid_en_before_reset", latch_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_latch_en", latch_en, 1'b0);
        check("mid_rst_latch_cdn", latch_cdn, 1'b0);
        check("mid_rst_latch_d", latch_d, 10'h000);
        check("mid_rst_busy", busy, 1'b1);
        check("mid_rst_ack", upd_ack, 1'b0);
        repeat (2) @(posedge clk);
        reset_exit();

        // Normal operation after the reset
        run_op(1'b1, 1'b0, 10'h30C, 0, ef, en, cn, an, ae, ie);
        check("post_rst_latch_d", latch_d, 10'h30C);
        check("post_rst_ack_edge", ae, 6);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
